inst_queue: RTL and testbench

//  Circular FIFO between instruction fetch and Decoder.

---
 rtl/inst_queue_pkg.sv | 17 +
 rtl/inst_queue_if.sv | 26 ++
 rtl/inst_queue.sv | 73 +++++++
 tb/tb_inst_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared constants and entry type for the fetch-to-decode instruction queue.
package inst_queue_pkg;

    localparam int IQ_ADDR_W = 4;
    localparam int IQ_DEPTH  = 16;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;

    // Near-full threshold keeps one spare slot for a fetcher that is a cycle late.
    function automatic logic iq_near_full(input int unsigned cnt, input int unsigned depth);
        return cnt >= depth - 1;
    endfunction

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side and decode-side handshake bundle for the instruction queue.
interface inst_queue_if;

    logic        IF_inst_valid;
    logic [31:0] IF_inst;
    logic [31:0] IF_pc;
    logic        IF_is_full;

    logic        IQ_inst_valid;
    logic [31:0] IQ_inst;
    logic [31:0] IQ_pc;
    logic        IQ_enable;

    // master: fetcher plus decoder driving the queue
    modport master (
        output IF_inst_valid, IF_inst, IF_pc, IQ_enable,
        input  IF_is_full, IQ_inst_valid, IQ_inst, IQ_pc
    );

    // slave: the queue itself
    modport slave (
        input  IF_inst_valid, IF_inst, IF_pc, IQ_enable,
        output IF_is_full, IQ_inst_valid, IQ_inst, IQ_pc
    );

endinterface

// File: rtl/inst_queue.sv
// Circular show-ahead FIFO of {inst, pc} between fetch and decode,
// cleared on branch mispredict and frozen while rdy is low.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int ADDR_W = IQ_ADDR_W,
    parameter int DEPTH  = IQ_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          ROB_flush,
    inst_queue_if.slave   q
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    iq_entry_t         r_buf [DEPTH];
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_tail;
    logic [ADDR_W:0]   r_count;
    logic              r_full;

    logic              w_active;
    logic              w_push;
    logic              w_pop;
    logic              w_nonempty;
    logic [ADDR_W:0]   w_count_nxt;
    iq_entry_t         w_head_entry;

    assign w_active   = rdy & ~ROB_flush;
    assign w_nonempty = (r_count != '0);

    // IF_is_full rises one entry early; the last physical slot still accepts
    // the push a fetcher may have committed before seeing the flag.
    assign w_push = w_active & q.IF_inst_valid & (r_count != L_DEPTH);
    assign w_pop  = w_active & q.IQ_enable & w_nonempty;

    assign w_count_nxt = r_count + {{ADDR_W{1'b0}}, w_push} - {{ADDR_W{1'b0}}, w_pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (rdy) begin
            if (ROB_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_full  <= 1'b0;
            end else begin
                if (w_push) r_tail <= r_tail + 1'b1;
                if (w_pop)  r_head <= r_head + 1'b1;
                r_count <= w_count_nxt;
                r_full  <= iq_near_full(32'(w_count_nxt), DEPTH);
            end
        end
    end

    // Storage carries no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) r_buf[r_tail] <= '{inst: q.IF_inst, pc: q.IF_pc};
    end

    assign w_head_entry    = r_buf[r_head];
    assign q.IF_is_full    = r_full;
    assign q.IQ_inst_valid = w_nonempty;
    assign q.IQ_inst       = w_nonempty ? w_head_entry.inst : 32'h0;
    assign q.IQ_pc         = w_nonempty ? w_head_entry.pc   : 32'h0;

endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: directed pushes enqueue expected entries,
// a negedge monitor checks every accepted pop against them.
module tb_inst_queue;
    import inst_queue_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    logic ROB_flush = 1'b0;

    inst_queue_if q();

    inst_queue dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .ROB_flush (ROB_flush),
        .q         (q)
    );

    always #5 clk = ~clk;

    int        n_vec = 0;
    int        n_bad = 0;
    bit        mon_en = 1'b0;
    iq_entry_t exp_q [$];

    function automatic logic [31:0] mk(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // One clock of stimulus; acc says whether the queue should take the push.
    task automatic cyc(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic en, input logic acc);
        q.IF_inst_valid = v;
        q.IF_inst       = inst;
        q.IF_pc         = pc;
        q.IQ_enable     = en;
        if (acc) exp_q.push_back('{inst: inst, pc: pc});
        @(posedge clk);
        #1;
        q.IF_inst_valid = 1'b0;
        q.IQ_enable     = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic acc);
        cyc(1'b1, mk(pc), pc, 1'b0, acc);
    endtask

    task automatic pop();
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic drain(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            check({name, "_valid"}, {31'h0, q.IQ_inst_valid}, 32'h1);
            pop();
        end
        check({name, "_empty"}, {31'h0, q.IQ_inst_valid}, 32'h0);
        check({name, "_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst && rdy && !ROB_flush && q.IQ_enable && q.IQ_inst_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL pop_extra: got pc %h, want no entry", q.IQ_pc);
            end else begin
                iq_entry_t e;
                e = exp_q.pop_front();
                check("pop_pc", q.IQ_pc, e.pc);
                check("pop_inst", q.IQ_inst, e.inst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        q.IF_inst_valid = 1'b0;
        q.IF_inst       = 32'h0;
        q.IF_pc         = 32'h0;
        q.IQ_enable     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'h0, q.IQ_inst_valid}, 32'h0);
        check("rst_inst",  q.IQ_inst, 32'h0);
        check("rst_pc",    q.IQ_pc, 32'h0);
        check("rst_full",  {31'h0, q.IF_is_full}, 32'h0);
        rst = 1'b1;
        mon_en = 1'b1;

        // push then pop
        cyc(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b1);
        check("t2_pc0",   q.IQ_pc, 32'h0);
        check("t2_inst0", q.IQ_inst, 32'h0050_0093);
        check("t2_valid", {31'h0, q.IQ_inst_valid}, 32'h1);
        cyc(1'b1, 32'h00A0_0113, 32'h4, 1'b0, 1'b1);
        check("t2_hold",  q.IQ_pc, 32'h0);
        pop();
        check("t2_pc4",   q.IQ_pc, 32'h4);
        check("t2_inst4", q.IQ_inst, 32'h00A0_0113);
        pop();
        check("t2_empty", {31'h0, q.IQ_inst_valid}, 32'h0);
        check("t2_zinst", q.IQ_inst, 32'h0);
        check("t2_zpc",   q.IQ_pc, 32'h0);
        pop();
        check("t2_idle",  {31'h0, q.IQ_inst_valid}, 32'h0);

        // fill to the last slot and past it
        for (int i = 0; i < 15; i++) begin
            check("t3_notfull", {31'h0, q.IF_is_full}, 32'h0);
            push(32'(i * 4), 1'b1);
        end
        check("t3_full15", {31'h0, q.IF_is_full}, 32'h1);
        push(32'h3C, 1'b1);
        check("t3_full16", {31'h0, q.IF_is_full}, 32'h1);
        push(32'h40, 1'b0);
        check("t3_head", q.IQ_pc, 32'h0);
        drain(16, "t3");
        check("t3_fullclr", {31'h0, q.IF_is_full}, 32'h0);

        // simultaneous push and pop at count 5
        for (int i = 0; i < 5; i++) push(32'h100 + 32'(i * 4), 1'b1);
        cyc(1'b1, mk(32'h114), 32'h114, 1'b1, 1'b1);
        check("t4_head", q.IQ_pc, 32'h104);
        drain(5, "t4");

        // 40 push/pop pairs across the pointer wrap
        push(32'h1000, 1'b1);
        for (int i = 1; i <= 40; i++) cyc(1'b1, mk(32'h1000 + 32'(i * 4)), 32'h1000 + 32'(i * 4), 1'b1, 1'b1);
        check("t5_head", q.IQ_pc, 32'h10A0);
        drain(1, "t5");

        // flush with a same-cycle push
        for (int i = 0; i < 7; i++) push(32'h2000 + 32'(i * 4), 1'b1);
        exp_q.delete();
        ROB_flush = 1'b1;
        push(32'h3000, 1'b0);
        ROB_flush = 1'b0;
        check("t6_flvalid", {31'h0, q.IQ_inst_valid}, 32'h0);
        check("t6_flinst",  q.IQ_inst, 32'h0);
        check("t6_flfull",  {31'h0, q.IF_is_full}, 32'h0);
        push(32'h3100, 1'b1);
        check("t6_after", q.IQ_pc, 32'h3100);
        drain(1, "t6a");

        // freeze with push and pop requested
        for (int i = 0; i < 3; i++) push(32'h4000 + 32'(i * 4), 1'b1);
        rdy = 1'b0;
        cyc(1'b1, mk(32'h5000), 32'h5000, 1'b1, 1'b0);
        cyc(1'b1, mk(32'h5004), 32'h5004, 1'b1, 1'b0);
        check("t6_frzpc", q.IQ_pc, 32'h4000);
        rdy = 1'b1;
        drain(3, "t6f");

        // asynchronous reset mid-operation
        push(32'h6000, 1'b1);
        push(32'h6004, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("t7_valid", {31'h0, q.IQ_inst_valid}, 32'h0);
        check("t7_pc",    q.IQ_pc, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        push(32'h7000, 1'b1);
        check("t7_after", q.IQ_pc, 32'h7000);
        drain(1, "t7");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
